// File: rtl/pong_pkg.sv
// Shared pong types and screen/paddle geometry, common to the ball painter and the border/paddle drawer.
package pong_pkg;

  typedef logic [2:0] colour_t;

  localparam int SCREEN_W = 320;
  localparam int SCREEN_H = 240;

  localparam int P1_X     = 8;
  localparam int P2_X     = 308;
  localparam int PADDLE_W = 4;
  localparam int PADDLE_H = 30;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ERASE = 2'd1,
    ST_MOVE  = 2'd2,
    ST_DRAW  = 2'd3
  } paint_state_e;

endpackage

// File: rtl/ball_painter_if.sv
// Pixel-write port toward the VGA adapter: one registered write per cycle while plot is high.
interface ball_painter_if
  import pong_pkg::*;
();

  logic [8:0] x;
  logic [7:0] y;
  colour_t    colour;
  logic       plot;

  modport master (output x, y, colour, plot);
  modport slave  (input  x, y, colour, plot);

endinterface

// File: rtl/box_scanner.sv
// Raster-scans a SIZE x SIZE box from a base corner, column fastest, one registered pixel per cycle.
// start restarts the scan immediately; done flags the cycle carrying the last pixel.
module box_scanner #(
  parameter int SIZE = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_i,
  input  logic [8:0] base_x_i,
  input  logic [7:0] base_y_i,
  output logic [8:0] x_o,
  output logic [7:0] y_o,
  output logic       valid_o,
  output logic       done_o
);

  localparam int            CW   = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

  logic [CW-1:0] cx_q, cx_d, cy_q, cy_d;
  logic [8:0]    bx_q, x_q, x_d;
  logic [7:0]    by_q, y_q, y_d;
  logic          valid_q, valid_d;
  logic          last;

  assign last = (cx_q == LAST) && (cy_q == LAST);

  always_comb begin
    cx_d    = cx_q;
    cy_d    = cy_q;
    valid_d = valid_q;
    x_d     = x_q;
    y_d     = y_q;
    if (start_i) begin
      cx_d    = '0;
      cy_d    = '0;
      valid_d = 1'b1;
      x_d     = base_x_i;
      y_d     = base_y_i;
    end else if (valid_q) begin
      if (last) begin
        valid_d = 1'b0;
      end else begin
        if (cx_q == LAST) begin
          cx_d = '0;
          cy_d = cy_q + 1'b1;
        end else begin
          cx_d = cx_q + 1'b1;
        end
        x_d = bx_q + 9'(cx_d);
        y_d = by_q + 8'(cy_d);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cx_q    <= '0;
      cy_q    <= '0;
      bx_q    <= '0;
      by_q    <= '0;
      x_q     <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      x_q     <= x_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      if (start_i) begin
        bx_q <= base_x_i;
        by_q <= base_y_i;
      end
    end
  end

  assign x_o     = x_q;
  assign y_o     = y_q;
  assign valid_o = valid_q;
  assign done_o  = valid_q && last;

endmodule

// File: rtl/ball_painter.sv
// Owns the pong ball: per frame tick erase the old box, step with wall/paddle bounce and scoring, redraw.
// First pixel one cycle after tick, 2*BALL_SIZE^2+1 busy cycles; ticks arriving while busy are dropped.
module ball_painter
  import pong_pkg::*;
#(
  parameter int      BALL_SIZE   = 4,
  parameter int      STEP        = 1,
  parameter int      START_X     = 158,
  parameter int      START_Y     = 118,
  parameter colour_t BALL_COLOUR = 3'b111,
  parameter colour_t BG_COLOUR   = 3'b000
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           tick,
  input  logic [7:0]     p1_y,
  input  logic [7:0]     p2_y,
  ball_painter_if.master pix,
  output logic           busy,
  output logic           p1_point,
  output logic           p2_point
);

  localparam logic [1:0] S_IDLE  = ST_IDLE;
  localparam logic [1:0] S_ERASE = ST_ERASE;
  localparam logic [1:0] S_MOVE  = ST_MOVE;
  localparam logic [1:0] S_DRAW  = ST_DRAW;

  localparam logic signed [9:0] BS  = 10'(BALL_SIZE);
  localparam logic signed [9:0] STP = 10'(STEP);
  localparam logic signed [9:0] SW  = 10'(SCREEN_W);
  localparam logic signed [9:0] SH  = 10'(SCREEN_H);
  localparam logic signed [9:0] PH  = 10'(PADDLE_H);
  localparam logic signed [9:0] P1F = 10'(P1_X + PADDLE_W);
  localparam logic signed [9:0] P2F = 10'(P2_X);
  localparam logic signed [9:0] SX  = 10'(START_X);
  localparam logic signed [9:0] SY  = 10'(START_Y);

  logic [1:0] state_q, state_d;
  logic [8:0] ball_x_q, ball_x_d;
  logic [7:0] ball_y_q, ball_y_d;
  logic       dir_x_q, dir_x_d;   // 1 = right
  logic       dir_y_q, dir_y_d;   // 1 = down
  colour_t    colour_q, colour_d;
  logic       busy_q, p1_point_q, p2_point_q;

  logic       sc_start, sc_valid, sc_done;
  logic [8:0] sc_x;
  logic [7:0] sc_y;

  logic signed [9:0] bx, by, nx, ny, p1t, p2t;
  logic              ndx, ndy, miss_r, miss_l, erase_done;

  // Next position is a pure function of the current ball, so it is ready by the end of ERASE.
  always_comb begin
    bx     = $signed({1'b0, ball_x_q});
    by     = $signed({2'b00, ball_y_q});
    p1t    = $signed({2'b00, p1_y});
    p2t    = $signed({2'b00, p2_y});
    miss_r = 1'b0;
    miss_l = 1'b0;

    ny  = dir_y_q ? by + STP : by - STP;
    ndy = dir_y_q;
    if (ny < 10'sd0) begin
      ny  = '0;
      ndy = ~dir_y_q;
    end else if (ny + BS > SH) begin
      ny  = SH - BS;
      ndy = ~dir_y_q;
    end

    nx  = dir_x_q ? bx + STP : bx - STP;
    ndx = dir_x_q;
    if (dir_x_q) begin
      if ((bx + BS <= P2F) && (nx + BS > P2F) && (ny + BS > p2t) && (ny < p2t + PH)) begin
        nx  = P2F - BS;
        ndx = 1'b0;
      end else if (nx + BS > SW) begin
        miss_r = 1'b1;
        nx     = SX;
        ny     = SY;
        ndx    = 1'b0;
      end
    end else begin
      if ((bx >= P1F) && (nx < P1F) && (ny + BS > p1t) && (ny < p1t + PH)) begin
        nx  = P1F;
        ndx = 1'b1;
      end else if (nx < 10'sd0) begin
        miss_l = 1'b1;
        nx     = SX;
        ny     = SY;
        ndx    = 1'b1;
      end
    end
  end

  assign erase_done = (state_q == S_ERASE) && sc_done;

  always_comb begin
    state_d  = state_q;
    colour_d = colour_q;
    sc_start = 1'b0;
    ball_x_d = ball_x_q;
    ball_y_d = ball_y_q;
    dir_x_d  = dir_x_q;
    dir_y_d  = dir_y_q;
    case (state_q)
      S_IDLE: begin
        if (tick) begin
          state_d  = S_ERASE;
          sc_start = 1'b1;
          colour_d = BG_COLOUR;
        end
      end
      S_ERASE: begin
        if (sc_done) begin
          state_d  = S_MOVE;
          ball_x_d = nx[8:0];
          ball_y_d = ny[7:0];
          dir_x_d  = ndx;
          dir_y_d  = ndy;
        end
      end
      S_MOVE: begin
        state_d  = S_DRAW;
        sc_start = 1'b1;
        colour_d = BALL_COLOUR;
      end
      S_DRAW: begin
        if (sc_done) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      ball_x_q   <= 9'(START_X);
      ball_y_q   <= 8'(START_Y);
      dir_x_q    <= 1'b1;
      dir_y_q    <= 1'b1;
      colour_q   <= '0;
      busy_q     <= 1'b0;
      p1_point_q <= 1'b0;
      p2_point_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ball_x_q   <= ball_x_d;
      ball_y_q   <= ball_y_d;
      dir_x_q    <= dir_x_d;
      dir_y_q    <= dir_y_d;
      colour_q   <= colour_d;
      busy_q     <= (state_d != S_IDLE);
      p1_point_q <= erase_done && miss_r;
      p2_point_q <= erase_done && miss_l;
    end
  end

  // In MOVE the ball registers already hold the new position, so one base feeds both scans.
  box_scanner #(
    .SIZE (BALL_SIZE)
  ) u_scan (
    .clk      (clk),
    .rst      (rst),
    .start_i  (sc_start),
    .base_x_i (ball_x_q),
    .base_y_i (ball_y_q),
    .x_o      (sc_x),
    .y_o      (sc_y),
    .valid_o  (sc_valid),
    .done_o   (sc_done)
  );

  assign pix.x      = sc_x;
  assign pix.y      = sc_y;
  assign pix.colour = colour_q;
  assign pix.plot   = sc_valid;
  assign busy       = busy_q;
  assign p1_point   = p1_point_q;
  assign p2_point   = p2_point_q;

endmodule

// File: tb/tb_ball_painter.sv
// Scoreboard bench for ball_painter: a behavioural ball model queues expected pixel writes per tick.
module tb_ball_painter;
  import pong_pkg::*;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic       tick = 1'b0;
  logic [7:0] p1_y = 8'd100;
  logic [7:0] p2_y = 8'd200;
  logic       busy, p1_point, p2_point;

  ball_painter_if pix();

  ball_painter dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .p1_y     (p1_y),
    .p2_y     (p2_y),
    .pix      (pix),
    .busy     (busy),
    .p1_point (p1_point),
    .p2_point (p2_point)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  logic [19:0] exp_q[$];
  int busy_cnt, p1_cnt, p2_cnt, plot_cnt, pt_plot_cnt;
  int draw_x, draw_y;
  bit got_draw;

  always @(negedge clk) begin
    logic [19:0] e;
    if (busy === 1'b1) busy_cnt++;
    if (p1_point === 1'b1) p1_cnt++;
    if (p2_point === 1'b1) p2_cnt++;
    if ((p1_point === 1'b1 || p2_point === 1'b1) && pix.plot === 1'b1) pt_plot_cnt++;
    if (pix.plot === 1'b1) begin
      plot_cnt++;
      if (pix.colour == 3'd7 && !got_draw) begin
        got_draw = 1'b1;
        draw_x   = int'(pix.x);
        draw_y   = int'(pix.y);
      end
      if (exp_q.size() == 0) begin
        check("sb_unexpected_plot", exp_q.size(), 1);
      end else begin
        e = exp_q.pop_front();
        check("pix", {pix.x, pix.y, pix.colour}, e);
      end
    end
  end

  int mx, my, mdx, mdy;

  task automatic model_reset();
    mx = 158; my = 118; mdx = 1; mdy = 1;
  endtask

  task automatic push_box(input int bx, input int by, input int c);
    for (int cy = 0; cy < 4; cy++)
      for (int cx = 0; cx < 4; cx++)
        exp_q.push_back({9'(bx + cx), 8'(by + cy), 3'(c)});
  endtask

  task automatic model_tick(output int pt1, output int pt2);
    int nx, ny;
    pt1 = 0;
    pt2 = 0;
    push_box(mx, my, 0);
    ny = my + mdy;
    if (ny < 0) begin ny = 0; mdy = -mdy; end
    else if (ny > 236) begin ny = 236; mdy = -mdy; end
    nx = mx + mdx;
    if (mdx > 0) begin
      if (mx <= 304 && nx > 304 && ny > int'(p2_y) - 4 && ny < int'(p2_y) + 30) begin
        nx = 304; mdx = -1;
      end else if (nx > 316) begin
        pt1 = 1; nx = 158; ny = 118; mdx = -1;
      end
    end else begin
      if (mx >= 12 && nx < 12 && ny > int'(p1_y) - 4 && ny < int'(p1_y) + 30) begin
        nx = 12; mdx = 1;
      end else if (nx < 0) begin
        pt2 = 1; nx = 158; ny = 118; mdx = 1;
      end
    end
    mx = nx;
    my = ny;
    push_box(mx, my, 7);
  endtask

  task automatic clear_counts();
    busy_cnt = 0; p1_cnt = 0; p2_cnt = 0; plot_cnt = 0; pt_plot_cnt = 0; got_draw = 1'b0;
  endtask

  task automatic send_tick();
    @(posedge clk); #1 tick = 1'b1;
    @(posedge clk); #1 tick = 1'b0;
  endtask

  task automatic do_tick(input string tag);
    int e1, e2;
    clear_counts();
    model_tick(e1, e2);
    send_tick();
    repeat (40) @(posedge clk);
    #1;
    check({tag, "_busy_cycles"}, busy_cnt, 33);
    check({tag, "_plots"}, plot_cnt, 32);
    check({tag, "_p1_point"}, p1_cnt, e1);
    check({tag, "_p2_point"}, p2_cnt, e2);
    check({tag, "_queue_left"}, exp_q.size(), 0);
  endtask

  task automatic pulse_reset();
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
  endtask

  initial begin
    int e1, e2;
    clear_counts();
    repeat (3) @(posedge clk);
    #1;
    check("rst_plot", pix.plot, 0);
    check("rst_busy", busy, 0);
    check("rst_p1_point", p1_point, 0);
    check("rst_p2_point", p2_point, 0);
    check("rst_x", pix.x, 0);
    check("rst_y", pix.y, 0);
    check("rst_colour", pix.colour, 0);
    rst = 1'b0;
    model_reset();

    // Bottom-wall bounce, then right-paddle hit with p2_y=200.
    for (int t = 1; t <= 148; t++) begin
      do_tick("run1");
      if (t == 1)   begin check("t1_x", draw_x, 159);   check("t1_y", draw_y, 119); end
      if (t == 118) begin check("t118_x", draw_x, 276); check("t118_y", draw_y, 236); end
      if (t == 119) begin check("t119_x", draw_x, 277); check("t119_y", draw_y, 236); end
      if (t == 120) begin check("t120_y_up", draw_y, 235); end
      if (t == 147) begin check("t147_x", draw_x, 304); check("t147_y", draw_y, 208); end
      if (t == 148) begin check("t148_x_left", draw_x, 303); end
    end

    // Right miss with p2_y=0: point on tick 159, redraw at serve.
    p2_y = 8'd0;
    pulse_reset();
    exp_q.delete();
    model_reset();
    for (int t = 1; t <= 159; t++) begin
      do_tick("run2");
      if (t == 159) begin
        check("t159_p1_point", p1_cnt, 1);
        check("t159_point_no_plot", pt_plot_cnt, 0);
        check("t159_x", draw_x, 158);
        check("t159_y", draw_y, 118);
      end
    end

    // Second tick while busy is ignored.
    clear_counts();
    model_tick(e1, e2);
    send_tick();
    repeat (4) @(posedge clk);
    #1 tick = 1'b1;
    @(posedge clk); #1 tick = 1'b0;
    repeat (45) @(posedge clk);
    #1;
    check("busytick_plots", plot_cnt, 32);
    check("busytick_busy", busy_cnt, 33);
    check("busytick_queue", exp_q.size(), 0);

    // Reset during DRAW pixel 8 aborts; next tick starts from serve.
    clear_counts();
    model_tick(e1, e2);
    while (exp_q.size() > 24) void'(exp_q.pop_back());
    send_tick();
    repeat (24) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk); #1;
    check("abort_plot", pix.plot, 0);
    check("abort_busy", busy, 0);
    repeat (10) @(posedge clk);
    #1;
    check("abort_plots", plot_cnt, 24);
    check("abort_queue", exp_q.size(), 0);
    exp_q.delete();
    model_reset();
    do_tick("after_rst");
    check("after_rst_x", draw_x, 159);
    check("after_rst_y", draw_y, 119);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
